// File: rtl/sme_pkg.sv
// sme_pkg: shared state encoding, metacharacter codes and a case-folding helper for the
// sme_param_engine string-match engine.
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SEARCH,
        DONE
    } sme_state_t;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    // Map 'A'-'Z' onto 'a'-'z'; every other code passes through unchanged.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
    endfunction

endpackage

// File: rtl/sme_char_cmp.sv
// sme_char_cmp: combinational single-character compare. A '.' in the pattern matches any
// character. Build macro SME_CASE_FOLD_EN makes letters compare case-insensitively.
module sme_char_cmp
    import sme_pkg::*;
(
    input  logic [7:0] str_ch,
    input  logic [7:0] pat_ch,
    output logic       equal
);

    logic [7:0] str_f;
    logic [7:0] pat_f;

`ifdef SME_CASE_FOLD_EN
    assign str_f = to_lower(str_ch);
    assign pat_f = to_lower(pat_ch);
`else
    assign str_f = str_ch;
    assign pat_f = pat_ch;
`endif

    assign equal = (pat_ch == CH_DOT) || (str_f == pat_f);

endmodule

// File: rtl/sme_param_engine.sv
// sme_param_engine: byte-serial string/pattern loader and substring search engine supporting
// '^' '$' '.' '*' metacharacters, one character comparison per cycle, lowest start index wins.
// Build macro SME_CASE_FOLD_EN enables case-insensitive letter comparison.
module sme_param_engine
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    localparam int IDX_W = $clog2(STR_MAX),
    localparam int LEN_W = $clog2(STR_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             busy,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index,
    output logic [LEN_W-1:0] match_len,
    output logic             err
);

    localparam int PIDX_W = $clog2(PAT_MAX);
    localparam int PLEN_W = $clog2(PAT_MAX + 1);
    localparam logic [LEN_W-1:0]  STR_FULL = LEN_W'(STR_MAX);
    localparam logic [PLEN_W-1:0] PAT_FULL = PLEN_W'(PAT_MAX);

    sme_state_t        state;
    logic [7:0]        str_buf [STR_MAX];
    logic [7:0]        pat_buf [PAT_MAX];
    logic [LEN_W-1:0]  str_len, si, star_si;
    logic [PLEN_W-1:0] pat_len, pi, star_pi;
    logic [IDX_W-1:0]  st;
    logic              star_valid, str_err, pat_err;

    logic              loading, str_first, pat_first, str_we, pat_we;
    logic [IDX_W-1:0]  str_wa, prev_idx;
    logic [PIDX_W-1:0] pat_wa;
    logic [7:0]        s_cur, s_prev, p_cur;
    logic              cmp_eq, in_str, pat_end, is_meta, step_ok, consume;
    logic              fin_hit, fin, star_more, start_more;
    logic [LEN_W-1:0]  hit_len;

    sme_char_cmp u_cmp (
        .str_ch (s_cur),
        .pat_ch (p_cur),
        .equal  (cmp_eq)
    );

    // Load write enables and per-cycle search step evaluation.
    always_comb begin
        loading   = (state != SEARCH);
        str_first = (state != LOAD_STR);
        pat_first = (state != LOAD_PAT);
        str_we    = loading && isstring && (str_first || (str_len < STR_FULL));
        pat_we    = loading && ispattern && !isstring && (pat_first || (pat_len < PAT_FULL));
        str_wa    = str_first ? '0 : str_len[IDX_W-1:0];
        pat_wa    = pat_first ? '0 : pat_len[PIDX_W-1:0];

        // Out-of-range reads are harmless: in_str / pat_end gate every use.
        prev_idx  = si[IDX_W-1:0] - 1'b1;
        s_cur     = str_buf[si[IDX_W-1:0]];
        s_prev    = str_buf[prev_idx];
        p_cur     = pat_buf[pi[PIDX_W-1:0]];
        in_str    = (si < str_len);
        pat_end   = (pi == pat_len);
        is_meta   = (p_cur == CH_STAR) || (p_cur == CH_CARET) || (p_cur == CH_DOLLAR);

        if (p_cur == CH_STAR) begin
            step_ok = 1'b1;
        end else if (p_cur == CH_CARET) begin
            step_ok = (si == '0) || (s_prev == CH_SPACE);
        end else if (p_cur == CH_DOLLAR) begin
            step_ok = !in_str || (s_cur == CH_SPACE);
        end else begin
            step_ok = in_str && cmp_eq;
        end
        consume    = in_str && !is_meta;

        star_more  = (star_si < str_len);
        start_more = ((LEN_W'(st) + 1'b1) < str_len);
        hit_len    = si - LEN_W'(st);
        fin_hit    = !pat_err && pat_end;
        // A '*' that has swallowed the rest of the string cannot succeed from any later start
        // either, so the whole search ends there.
        fin        = pat_err || fin_hit ||
                     (!pat_end && !step_ok && (star_valid ? !star_more : !start_more));
    end

    // Character buffers; contents need no reset since the lengths qualify them.
    always_ff @(posedge clk) begin
        if (str_we) str_buf[str_wa] <= chardata;
        if (pat_we) pat_buf[pat_wa] <= chardata;
    end

    // Control FSM, load counters, search pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            str_len     <= '0;
            pat_len     <= '0;
            str_err     <= 1'b0;
            pat_err     <= 1'b0;
            st          <= '0;
            si          <= '0;
            pi          <= '0;
            star_si     <= '0;
            star_pi     <= '0;
            star_valid  <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_len   <= '0;
            err         <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                SEARCH: begin
                    if (fin) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        match       <= fin_hit;
                        match_index <= fin_hit ? st : '0;
                        match_len   <= fin_hit ? hit_len : '0;
                        err         <= str_err | pat_err;
                    end else if (pat_end) begin
                        state <= DONE;  // unreachable: pat_end always finishes
                    end else if (step_ok) begin
                        if (p_cur == CH_STAR) begin
                            star_valid <= 1'b1;
                            star_pi    <= pi;
                            star_si    <= si;
                        end
                        if (consume) si <= si + 1'b1;
                        pi <= pi + 1'b1;
                    end else if (star_valid) begin
                        // Let the last '*' absorb one more character and retry after it.
                        star_si <= star_si + 1'b1;
                        si      <= star_si + 1'b1;
                        pi      <= star_pi + 1'b1;
                    end else begin
                        st <= st + 1'b1;
                        si <= LEN_W'(st) + 1'b1;
                        pi <= '0;
                    end
                end
                IDLE, LOAD_STR, LOAD_PAT, DONE: begin
                    if (isstring) begin
                        state <= LOAD_STR;
                        if (str_first) begin
                            str_len <= LEN_W'(1);
                            str_err <= 1'b0;
                        end else if (str_len < STR_FULL) begin
                            str_len <= str_len + 1'b1;
                        end else begin
                            str_err <= 1'b1;
                        end
                    end else if (ispattern) begin
                        state <= LOAD_PAT;
                        if (pat_first) begin
                            pat_len <= PLEN_W'(1);
                            pat_err <= 1'b0;
                        end else if (pat_len < PAT_FULL) begin
                            pat_len <= pat_len + 1'b1;
                        end else begin
                            pat_err <= 1'b1;
                        end
                    end else if (state == LOAD_PAT) begin
                        // No string since reset means nothing to search.
                        if (str_len != '0) begin
                            state      <= SEARCH;
                            busy       <= 1'b1;
                            st         <= '0;
                            si         <= '0;
                            pi         <= '0;
                            star_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
